// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
// Instruction-fetch prefetch front end. Issues pipelined fetches over an
// SRAM-like addr_ok/data_ok interface and allows several requests in flight.
// Returned {pc,inst} pairs are buffered in a DEPTH-entry queue that feeds the
// ID stage. A branch redirect flushes the queue, and responses that are still
// in flight at that point are marked stale and dropped when they return.
//
// Ports
//   clk             in   1   clock
//   reset           in   1   synchronous active-high reset
//   br_redirect     in   1   one-cycle redirect pulse from the branch unit
//   br_target       in   32  redirect target PC (bits [1:0] ignored)
//   inst_req        out  1   fetch request valid
//   inst_addr       out  32  fetch address (word aligned)
//   inst_addr_ok    in   1   request accepted this cycle
//   inst_data_ok    in   1   one response this cycle, in request order
//   inst_rdata      in   32  response instruction
//   ds_allow_in     in   1   ID stage can accept
//   fs_to_ds_valid  out  1   queue head valid
//   fs_ds_bus       out  64  {pc, inst} of the queue head
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        ds_allow_in,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_ds_bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          reset_d;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] q_count;
  logic [CW-1:0] discard;

  // In-order record of the pc of every accepted request still in flight.
  logic [31:0]   pc_fifo [DEPTH];
  logic [AW-1:0] pf_wr;
  logic [AW-1:0] pf_rd;

  // Instruction queue towards decode.
  logic [63:0]   q_mem [DEPTH];
  logic [AW-1:0] q_wr;
  logic [AW-1:0] q_rd;

  logic [CW:0]   credit_sum;
  logic          accept;
  logic          resp;
  logic          drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_next;

  // Stale requests still hold credit, so in-flight plus buffered never
  // exceeds DEPTH and a response always finds room in the queue.
  assign credit_sum = {1'b0, outstanding} + {1'b0, q_count};
  assign inst_req   = ~reset & ~reset_d & (credit_sum < DEPTH_W);
  assign inst_addr  = fetch_pc;

  assign accept = inst_req & inst_addr_ok;
  assign resp   = inst_data_ok;
  assign drop   = resp & (discard != {CW{1'b0}});
  // Redirect flushes the queue: a response landing this cycle is dropped and
  // the head is not consumed even if ID signals it can accept.
  assign push   = resp & ~drop & ~br_redirect;
  assign pop    = fs_to_ds_valid & ds_allow_in & ~br_redirect;

  assign outstanding_next = outstanding + CW'(accept) - CW'(resp);

  assign fs_to_ds_valid = (q_count != {CW{1'b0}});
  assign fs_ds_bus      = fs_to_ds_valid ? q_mem[q_rd] : 64'd0;

  // Fetch pc, in-flight tracking, stale-response accounting and queue state.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      reset_d     <= 1'b1;
      outstanding <= {CW{1'b0}};
      q_count     <= {CW{1'b0}};
      discard     <= {CW{1'b0}};
      pf_wr       <= {AW{1'b0}};
      pf_rd       <= {AW{1'b0}};
      q_wr        <= {AW{1'b0}};
      q_rd        <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_fifo[i] <= 32'd0;
        q_mem[i]   <= 64'd0;
      end
    end else begin
      reset_d     <= 1'b0;
      outstanding <= outstanding_next;

      if (accept) begin
        pc_fifo[pf_wr] <= fetch_pc;
        pf_wr          <= pf_wr + AW'(1);
      end else begin
        pf_wr <= pf_wr;
      end

      // Stale responses still pop their pc entry so the FIFO stays aligned.
      if (resp) begin
        pf_rd <= pf_rd + AW'(1);
      end else begin
        pf_rd <= pf_rd;
      end

      if (br_redirect) begin
        // Everything accepted so far (including this cycle) and not yet
        // returned is stale; a request accepted now used the old pc.
        fetch_pc <= br_target & ~32'd3;
        discard  <= outstanding_next;
        q_count  <= {CW{1'b0}};
        q_wr     <= {AW{1'b0}};
        q_rd     <= {AW{1'b0}};
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end else begin
          fetch_pc <= fetch_pc;
        end

        if (drop) begin
          discard <= discard - CW'(1);
        end else begin
          discard <= discard;
        end

        if (push) begin
          q_mem[q_wr] <= {pc_fifo[pf_rd], inst_rdata};
          q_wr        <= q_wr + AW'(1);
        end else begin
          q_wr <= q_wr;
        end

        if (pop) begin
          q_rd <= q_rd + AW'(1);
        end else begin
          q_rd <= q_rd;
        end

        q_count <= q_count + CW'(push) - CW'(pop);
      end
    end
  end

  if_prefetch_stage_chk #(.CW(CW)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .resp        (resp),
    .q_count     (q_count),
    .outstanding (outstanding),
    .depth       (DEPTH_C)
  );

endmodule

// ---------------------------------------------------------------------------
// if_prefetch_stage_chk
// Protocol/safety checks for the prefetch stage: no push into a full queue
// and no response while nothing is outstanding.
// Ports: clk, reset, push, resp, q_count, outstanding, depth (all inputs).
// ---------------------------------------------------------------------------
module if_prefetch_stage_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          push,
  input logic          resp,
  input logic [CW-1:0] q_count,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] depth
);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (q_count >= depth)));

  a_no_spurious_resp: assert property (@(posedge clk) disable iff (reset)
    !(resp && (outstanding == {CW{1'b0}})));

endmodule
